fragment_interpolator: RTL and testbench

Downstream consumer of the triangle rasterizer's fragment stream. It buffers each fragment (x, y, three signed edge-function weights) in a small FIFO, then normalises the weights against the triangle's doubled area using a multi-cycle restoring divider. The result is an interpolated per-pixel intensity from three per-triangle vertex intensities. Output is a valid/ready pixel stream toward the framebuffer writer; the FIFO absorbs the rasterizer's lack of backpressure.

---
 rtl/fragment_interpolator.sv | 165 ++++++++++++++++
 tb/tb_fragment_interpolator.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fragment_interpolator.sv
`default_nettype none
// fragment_interpolator: buffers rasterizer fragments and interpolates a per-pixel
// intensity from three vertex intensities via a restoring divider.  Rev 1.0
module fragment_interpolator #(
  parameter int CORD_WIDTH  = 10,
  parameter int COLOR_WIDTH = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_tri_load,
  input  logic [COLOR_WIDTH-1:0]      i_c0,
  input  logic [COLOR_WIDTH-1:0]      i_c1,
  input  logic [COLOR_WIDTH-1:0]      i_c2,
  input  logic                        i_frag_valid,
  input  logic [CORD_WIDTH-1:0]       i_frag_x,
  input  logic [CORD_WIDTH-1:0]       i_frag_y,
  input  logic [2*CORD_WIDTH:0]       i_lambda0,
  input  logic [2*CORD_WIDTH:0]       i_lambda1,
  input  logic [2*CORD_WIDTH:0]       i_lambda2,
  output logic                        o_pix_valid,
  input  logic                        i_pix_ready,
  output logic [CORD_WIDTH-1:0]       o_pix_x,
  output logic [CORD_WIDTH-1:0]       o_pix_y,
  output logic [COLOR_WIDTH-1:0]      o_pix_color,
  output logic                        o_busy,
  output logic                        o_overflow
);

  localparam int LW   = 2*CORD_WIDTH + 1;
  localparam int SW   = 2*CORD_WIDTH + 3;
  localparam int NW   = 2*CORD_WIDTH + COLOR_WIDTH + 3;
  localparam int EW   = 2*CORD_WIDTH + 3*LW;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = $clog2(COLOR_WIDTH);
  localparam logic [PW:0]      FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [CNTW-1:0]  LAST = CNTW'(COLOR_WIDTH-1);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, OUT = 2'd3} state_t;

  state_t                 state;
  logic [EW-1:0]          mem [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [PW:0]            count;
  logic                   push, pop;
  logic [COLOR_WIDTH-1:0] c0, c1, c2;
  logic [CORD_WIDTH-1:0]  cur_x, cur_y;
  logic [LW-1:0]          cur_l0, cur_l1, cur_l2;
  logic [NW-1:0]          rem, dvs, rem_sub, n_val;
  logic [COLOR_WIDTH-2:0] quo;
  logic [CNTW-1:0]        cnt;
  logic                   sat, degen, ge;
  logic [LW-1:0]          a0, a1, a2;
  logic [SW-1:0]          sum, d_mag;

  assign o_busy = (count != '0) || (state != IDLE);
  assign push   = i_frag_valid && (count < FULL);
  assign pop    = (state == IDLE) && (count != '0);

  function automatic logic [LW-1:0] mag(input logic [LW-1:0] v);
    return v[LW-1] ? (~v + 1'b1) : v;
  endfunction

  always_comb begin
    a0      = mag(cur_l0);
    a1      = mag(cur_l1);
    a2      = mag(cur_l2);
    sum     = SW'(signed'(cur_l0)) + SW'(signed'(cur_l1)) + SW'(signed'(cur_l2));
    d_mag   = sum[SW-1] ? (~sum + 1'b1) : sum;
    n_val   = NW'(a0) * NW'(c0) + NW'(a1) * NW'(c1) + NW'(a2) * NW'(c2);
    ge      = (rem >= dvs);
    rem_sub = rem - dvs;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {i_frag_x, i_frag_y, i_lambda0, i_lambda1, i_lambda2};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      c0          <= '0;
      c1          <= '0;
      c2          <= '0;
      cur_x       <= '0;
      cur_y       <= '0;
      cur_l0      <= '0;
      cur_l1      <= '0;
      cur_l2      <= '0;
      rem         <= '0;
      dvs         <= '0;
      quo         <= '0;
      cnt         <= '0;
      sat         <= 1'b0;
      degen       <= 1'b0;
      o_pix_valid <= 1'b0;
      o_pix_x     <= '0;
      o_pix_y     <= '0;
      o_pix_color <= '0;
      o_overflow  <= 1'b0;
    end else begin
      if (i_tri_load && !o_busy) begin
        c0         <= i_c0;
        c1         <= i_c1;
        c2         <= i_c2;
        o_overflow <= 1'b0;
      end
      if (i_frag_valid && !push) o_overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (pop) begin
            {cur_x, cur_y, cur_l0, cur_l1, cur_l2} <= mem[rd_ptr];
            state <= MUL;
          end
        end
        MUL: begin
          // Divisor starts aligned to the quotient MSB; a quotient that would
          // need more than COLOR_WIDTH bits is caught up front as saturation.
          rem   <= n_val;
          dvs   <= {1'b0, d_mag, {(COLOR_WIDTH-1){1'b0}}};
          sat   <= (n_val >= {d_mag, {COLOR_WIDTH{1'b0}}});
          degen <= (d_mag == '0);
          cnt   <= '0;
          state <= DIV;
        end
        DIV: begin
          if (ge) rem <= rem_sub;
          dvs <= dvs >> 1;
          quo <= {quo[COLOR_WIDTH-3:0], ge};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            o_pix_valid <= 1'b1;
            o_pix_x     <= cur_x;
            o_pix_y     <= cur_y;
            o_pix_color <= degen ? c0 : (sat ? '1 : {quo, ge});
            state       <= OUT;
          end
        end
        OUT: begin
          if (i_pix_ready) begin
            o_pix_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fragment_interpolator.sv
`default_nettype none
// Directed self-checking bench for fragment_interpolator.
module tb_fragment_interpolator;

  localparam int CW = 10;
  localparam int C  = 8;
  localparam int LW = 2*CW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tri_load = 1'b0;
  logic [C-1:0]  c0 = '0, c1 = '0, c2 = '0;
  logic          frag_valid = 1'b0;
  logic [CW-1:0] frag_x = '0, frag_y = '0;
  logic [LW-1:0] l0 = '0, l1 = '0, l2 = '0;
  logic          pix_valid;
  logic          pix_ready = 1'b0;
  logic [CW-1:0] pix_x, pix_y;
  logic [C-1:0]  pix_color;
  logic          busy, overflow;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  fragment_interpolator #(.CORD_WIDTH(CW), .COLOR_WIDTH(C), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_tri_load(tri_load),
    .i_c0(c0), .i_c1(c1), .i_c2(c2),
    .i_frag_valid(frag_valid), .i_frag_x(frag_x), .i_frag_y(frag_y),
    .i_lambda0(l0), .i_lambda1(l1), .i_lambda2(l2),
    .o_pix_valid(pix_valid), .i_pix_ready(pix_ready),
    .o_pix_x(pix_x), .o_pix_y(pix_y), .o_pix_color(pix_color),
    .o_busy(busy), .o_overflow(overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_tri(input logic [C-1:0] a, input logic [C-1:0] b, input logic [C-1:0] c);
    tri_load = 1'b1; c0 = a; c1 = b; c2 = c;
    tick();
    tri_load = 1'b0;
  endtask

  task automatic push(input logic [CW-1:0] x, input logic [CW-1:0] y,
                      input logic [LW-1:0] a, input logic [LW-1:0] b, input logic [LW-1:0] c);
    frag_valid = 1'b1; frag_x = x; frag_y = y; l0 = a; l1 = b; l2 = c;
    tick();
    frag_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!pix_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    if (!pix_valid) chk("timeout_pix_valid", 32'(pix_valid), 32'd1);
  endtask

  task automatic recv(output logic [CW-1:0] x, output logic [CW-1:0] y, output logic [C-1:0] col);
    x = pix_x; y = pix_y; col = pix_color;
    pix_ready = 1'b1;
    tick();
    pix_ready = 1'b0;
  endtask

  task automatic one_pixel(input string tag, input logic [CW-1:0] x, input logic [CW-1:0] y,
                           input logic [LW-1:0] a, input logic [LW-1:0] b, input logic [LW-1:0] c,
                           input logic [C-1:0] exp_col);
    int cyc;
    logic [CW-1:0] rx, ry;
    logic [C-1:0]  rc;
    push(x, y, a, b, c);
    wait_valid(cyc);
    recv(rx, ry, rc);
    chk({tag, "_x"}, 32'(rx), 32'(x));
    chk({tag, "_y"}, 32'(ry), 32'(y));
    chk({tag, "_color"}, 32'(rc), 32'(exp_col));
    chk({tag, "_valid_fall"}, 32'(pix_valid), 32'd0);
  endtask

  initial begin
    int cyc;
    logic [CW-1:0] rx, ry;
    logic [C-1:0]  rc;
    logic          seen;
    logic [LW-1:0] ta [6];
    logic [LW-1:0] tb [6];
    logic [LW-1:0] tc [6];
    logic [C-1:0]  te [5];
    ta = '{-21'sd16, 21'sd0,   21'sd0,   -21'sd8, -21'sd5, -21'sd16};
    tb = '{21'sd0,   -21'sd16, 21'sd0,   -21'sd8, -21'sd5, 21'sd0};
    tc = '{21'sd0,   21'sd0,   -21'sd16, 21'sd0,  -21'sd6, 21'sd0};
    te = '{8'd200, 8'd100, 8'd0, 8'd150, 8'd93};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(pix_valid), 32'd0);
    chk("rst_x", 32'(pix_x), 32'd0);
    chk("rst_y", 32'(pix_y), 32'd0);
    chk("rst_color", 32'(pix_color), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    tick();

    load_tri(8'd200, 8'd100, 8'd0);

    // Latency from push to pix_valid
    push(10'd1, 10'd2, -21'sd16, 21'sd0, 21'sd0);
    wait_valid(cyc);
    chk("latency", 32'(cyc), 32'd10);
    recv(rx, ry, rc);
    chk("lat_x", 32'(rx), 32'd1);
    chk("lat_y", 32'(ry), 32'd2);
    chk("lat_color", 32'(rc), 32'd200);
    chk("lat_busy_fall", 32'(busy), 32'd0);

    one_pixel("mix", 10'd3, 10'd4, -21'sd8, -21'sd8, 21'sd0, 8'd150);
    one_pixel("floor", 10'd5, 10'd6, -21'sd5, -21'sd5, -21'sd6, 8'd93);
    one_pixel("pos", 10'd7, 10'd8, 21'sd5, 21'sd5, 21'sd6, 8'd93);
    one_pixel("degen", 10'd9, 10'd10, 21'sd0, 21'sd0, 21'sd0, 8'd200);
    chk("no_x", 32'($isunknown({pix_valid, pix_x, pix_y, pix_color, busy, overflow})), 32'd0);

    // Overflow: six back-to-back pushes with ready low
    for (int i = 0; i < 6; i++) push(CW'(11 + i), CW'(20 + i), ta[i], tb[i], tc[i]);
    chk("ovf_set", 32'(overflow), 32'd1);
    load_tri(8'd50, 8'd100, 8'd0);
    chk("ovf_kept_on_busy_load", 32'(overflow), 32'd1);
    wait_valid(cyc);
    repeat (3) tick();
    chk("hold_valid", 32'(pix_valid), 32'd1);
    chk("hold_x", 32'(pix_x), 32'd11);
    chk("hold_color", 32'(pix_color), 32'd200);
    for (int i = 0; i < 5; i++) begin
      wait_valid(cyc);
      recv(rx, ry, rc);
      chk($sformatf("burst%0d_x", i), 32'(rx), 32'(11 + i));
      chk($sformatf("burst%0d_y", i), 32'(ry), 32'(20 + i));
      chk($sformatf("burst%0d_color", i), 32'(rc), 32'(te[i]));
    end
    seen = 1'b0;
    repeat (15) begin
      tick();
      seen = seen | pix_valid;
    end
    chk("burst_no_sixth", 32'(seen), 32'd0);
    chk("burst_busy_low", 32'(busy), 32'd0);
    load_tri(8'd200, 8'd100, 8'd0);
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Load while busy is ignored
    push(10'd30, 10'd31, -21'sd16, 21'sd0, 21'sd0);
    repeat (3) tick();
    load_tri(8'd50, 8'd100, 8'd0);
    wait_valid(cyc);
    recv(rx, ry, rc);
    chk("busy_load_color", 32'(rc), 32'd200);
    tick();
    load_tri(8'd50, 8'd100, 8'd0);
    one_pixel("reload", 10'd32, 10'd33, -21'sd16, 21'sd0, 21'sd0, 8'd50);

    // Reset during DIV
    push(10'd40, 10'd41, -21'sd16, 21'sd0, 21'sd0);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(pix_valid), 32'd0);
    chk("mrst_x", 32'(pix_x), 32'd0);
    chk("mrst_y", 32'(pix_y), 32'd0);
    chk("mrst_color", 32'(pix_color), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_overflow", 32'(overflow), 32'd0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      tick();
      seen = seen | pix_valid;
    end
    chk("mrst_no_stale", 32'(seen), 32'd0);
    chk("mrst_busy_after", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
